// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, opcodes and ALU control codes for the ID/EX stage
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_e;

    typedef enum logic {
        OP2_RS2 = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side, writeback-snoop and ALU-side signals of the ID/EX stage
interface id_ex_stage_if #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RA_W = riscv_pkg::RA_W
) ();

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic            in_funct7_5;
    logic [RA_W-1:0] in_rs1;
    logic [RA_W-1:0] in_rs2;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc;
    logic [RA_W-1:0] in_rd;

    logic            exmem_we;
    logic [RA_W-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_we;
    logic [RA_W-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_result;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [3:0]      out_aluctrl;
    logic [XLEN-1:0] out_store_val;
    logic [2:0]      out_funct3;
    logic [RA_W-1:0] out_rd;
    logic            out_reg_we;

    modport master (
        output flush, in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2,
               in_rs1_val, in_rs2_val, in_imm, in_pc, in_rd,
               exmem_we, exmem_rd, exmem_result, memwb_we, memwb_rd, memwb_result,
               out_ready,
        input  in_ready, out_valid, out_op1, out_op2, out_aluctrl, out_store_val,
               out_funct3, out_rd, out_reg_we
    );

    modport slave (
        input  flush, in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2,
               in_rs1_val, in_rs2_val, in_imm, in_pc, in_rd,
               exmem_we, exmem_rd, exmem_result, memwb_we, memwb_rd, memwb_result,
               out_ready,
        output in_ready, out_valid, out_op1, out_op2, out_aluctrl, out_store_val,
               out_funct3, out_rd, out_reg_we
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - opcode/funct3/funct7_5 to ALU code, operand selects and writeback enable
module alu_ctrl_dec import riscv_pkg::*; (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_ctrl_e  aluctrl,
    output op1_sel_e   op1_sel,
    output op2_sel_e   op2_sel,
    output logic       shift_op,
    output logic       reg_we,
    output logic       use_rs1,
    output logic       use_rs2
);

    // funct7_5 means SUB only for register-register, but SRA for both forms.
    function automatic alu_ctrl_e arith_op(input logic [2:0] f3, input logic alt,
                                           input logic allow_sub);
        alu_ctrl_e op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        aluctrl  = ALU_ADD;
        op1_sel  = OP1_RS1;
        op2_sel  = OP2_IMM;
        shift_op = 1'b0;
        reg_we   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OP: begin
                aluctrl  = arith_op(funct3, funct7_5, 1'b1);
                op2_sel  = OP2_RS2;
                shift_op = (funct3[1:0] == 2'b01);
                reg_we   = 1'b1;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            OP_IMM: begin
                aluctrl  = arith_op(funct3, funct7_5, 1'b0);
                shift_op = (funct3[1:0] == 2'b01);
                reg_we   = 1'b1;
                use_rs1  = 1'b1;
            end
            LOAD, JALR: begin
                reg_we  = 1'b1;
                use_rs1 = 1'b1;
            end
            STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            BRANCH: begin
                // Equality tests subtract; ordered tests use the set-less-than flavours.
                if (!funct3[2])     aluctrl = ALU_SUB;
                else if (funct3[1]) aluctrl = ALU_SLTU;
                else                aluctrl = ALU_SLT;
                op2_sel = OP2_RS2;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            LUI: begin
                op1_sel = OP1_ZERO;
                reg_we  = 1'b1;
            end
            AUIPC, JAL: begin
                op1_sel = OP1_PC;
                reg_we  = 1'b1;
            end
            default: begin
                op2_sel = OP2_RS2;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX register: operand select, forwarding, ALU control. FWD_EN enables bypass muxes.
module id_ex_stage #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RA_W = riscv_pkg::RA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    import riscv_pkg::*;

    alu_ctrl_e       dec_aluctrl;
    op1_sel_e        dec_op1_sel;
    op2_sel_e        dec_op2_sel;
    logic            dec_shift;
    logic            dec_reg_we;
    logic            dec_use_rs1;
    logic            dec_use_rs2;

    logic            hazard_stall;
    logic            in_ready;
    logic            load;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    logic            valid_q,   valid_d;
    logic [XLEN-1:0] op1_q,     op1_d;
    logic [XLEN-1:0] op2_q,     op2_d;
    logic [XLEN-1:0] store_q,   store_d;
    alu_ctrl_e       aluctrl_q, aluctrl_d;
    logic [2:0]      funct3_q,  funct3_d;
    logic [RA_W-1:0] rd_q,      rd_d;
    logic            reg_we_q,  reg_we_d;

    // x0 is never a producer, so an rd of zero can never match.
    function automatic logic rs_hit(input logic [RA_W-1:0] rs, input logic we,
                                    input logic [RA_W-1:0] rd);
        return we && (rd != '0) && (rs == rd);
    endfunction

    alu_ctrl_dec u_dec (
        .opcode   (bus.in_opcode),
        .funct3   (bus.in_funct3),
        .funct7_5 (bus.in_funct7_5),
        .aluctrl  (dec_aluctrl),
        .op1_sel  (dec_op1_sel),
        .op2_sel  (dec_op2_sel),
        .shift_op (dec_shift),
        .reg_we   (dec_reg_we),
        .use_rs1  (dec_use_rs1),
        .use_rs2  (dec_use_rs2)
    );

`ifdef FWD_EN
    always_comb begin
        rs1_fwd = bus.in_rs1_val;
        if (rs_hit(bus.in_rs1, bus.exmem_we, bus.exmem_rd))
            rs1_fwd = bus.exmem_result;
        else if (rs_hit(bus.in_rs1, bus.memwb_we, bus.memwb_rd))
            rs1_fwd = bus.memwb_result;
        rs2_fwd = bus.in_rs2_val;
        if (rs_hit(bus.in_rs2, bus.exmem_we, bus.exmem_rd))
            rs2_fwd = bus.exmem_result;
        else if (rs_hit(bus.in_rs2, bus.memwb_we, bus.memwb_rd))
            rs2_fwd = bus.memwb_result;
    end
    assign hazard_stall = 1'b0;
`else
    assign rs1_fwd = bus.in_rs1_val;
    assign rs2_fwd = bus.in_rs2_val;
    // Without bypassing, hold the instruction until no in-flight writer targets a used source.
    assign hazard_stall = bus.in_valid &
        ((dec_use_rs1 & (rs_hit(bus.in_rs1, bus.exmem_we, bus.exmem_rd) |
                         rs_hit(bus.in_rs1, bus.memwb_we, bus.memwb_rd))) |
         (dec_use_rs2 & (rs_hit(bus.in_rs2, bus.exmem_we, bus.exmem_rd) |
                         rs_hit(bus.in_rs2, bus.memwb_we, bus.memwb_rd))));
`endif

    always_comb begin
        op1 = rs1_fwd;
        case (dec_op1_sel)
            OP1_PC:   op1 = bus.in_pc;
            OP1_ZERO: op1 = '0;
            default:  op1 = rs1_fwd;
        endcase
        src2 = (dec_op2_sel == OP2_IMM) ? bus.in_imm : rs2_fwd;
        op2  = dec_shift ? {{(XLEN-5){1'b0}}, src2[4:0]} : src2;
    end

    // A flush always makes room: whatever arrives alongside it is swallowed.
    assign in_ready = bus.flush | ((~valid_q | bus.out_ready) & ~hazard_stall);
    assign load     = bus.in_valid & in_ready & ~bus.flush;

    always_comb begin
        valid_d   = valid_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        store_d   = store_q;
        aluctrl_d = aluctrl_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        reg_we_d  = reg_we_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d   = 1'b1;
            op1_d     = op1;
            op2_d     = op2;
            store_d   = rs2_fwd;
            aluctrl_d = dec_aluctrl;
            funct3_d  = bus.in_funct3;
            rd_d      = bus.in_rd;
            reg_we_d  = dec_reg_we;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            store_q   <= '0;
            aluctrl_q <= ALU_ADD;
            funct3_q  <= '0;
            rd_q      <= '0;
            reg_we_q  <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            store_q   <= store_d;
            aluctrl_q <= aluctrl_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            reg_we_q  <= reg_we_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = valid_q;
    assign bus.out_op1       = op1_q;
    assign bus.out_op2       = op2_q;
    assign bus.out_store_val = store_q;
    assign bus.out_aluctrl   = aluctrl_q;
    assign bus.out_funct3    = funct3_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_reg_we    = reg_we_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed vectors plus a reference model for id_ex_stage
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic cmp_en = 1'b0;

    id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] st;
        logic [3:0]  ctrl;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic m_valid = 1'b0;
    exp_t m_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic logic [31:0] src_val(input logic [4:0] rs, input logic [31:0] rf);
`ifdef FWD_EN
        if (rs != 0 && bus.exmem_we && bus.exmem_rd == rs) return bus.exmem_result;
        if (rs != 0 && bus.memwb_we && bus.memwb_rd == rs) return bus.memwb_result;
`endif
        return rf;
    endfunction

    function automatic logic busy(input logic [4:0] rs);
        return rs != 0 && ((bus.exmem_we && bus.exmem_rd == rs) ||
                           (bus.memwb_we && bus.memwb_rd == rs));
    endfunction

    function automatic logic pred_stall();
`ifdef FWD_EN
        return 1'b0;
`else
        logic reads1;
        logic reads2;
        reads1 = bus.in_opcode inside {OP, OP_IMM, LOAD, STORE, JALR, BRANCH};
        reads2 = bus.in_opcode inside {OP, STORE, BRANCH};
        return bus.in_valid && ((reads1 && busy(bus.in_rs1)) || (reads2 && busy(bus.in_rs2)));
`endif
    endfunction

    function automatic logic pred_ready();
        return bus.flush || ((!m_valid || bus.out_ready) && !pred_stall());
    endfunction

    function automatic exp_t predict();
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        f3     = bus.in_funct3;
        a      = src_val(bus.in_rs1, bus.in_rs1_val);
        b      = src_val(bus.in_rs2, bus.in_rs2_val);
        e.st   = b;
        e.f3   = f3;
        e.rd   = bus.in_rd;
        e.we   = bus.in_opcode inside {OP, OP_IMM, LOAD, JALR, LUI, AUIPC, JAL};
        e.ctrl = 4'h0;
        e.op1  = a;
        e.op2  = b;
        case (bus.in_opcode)
            OP, OP_IMM: begin
                e.ctrl = {1'b0, f3};
                if (f3 == 3'd0 && bus.in_funct7_5 && bus.in_opcode == OP) e.ctrl = 4'h8;
                if (f3 == 3'd5 && bus.in_funct7_5) e.ctrl = 4'hF;
                if (bus.in_opcode == OP_IMM) e.op2 = bus.in_imm;
                if (f3 == 3'd1 || f3 == 3'd5) e.op2 = e.op2 % 32;
            end
            LOAD, STORE, JALR: e.op2 = bus.in_imm;
            LUI: begin
                e.op1 = 32'd0;
                e.op2 = bus.in_imm;
            end
            AUIPC, JAL: begin
                e.op1 = bus.in_pc;
                e.op2 = bus.in_imm;
            end
            BRANCH: begin
                if (f3 < 3'd4)      e.ctrl = 4'h8;
                else if (f3 < 3'd6) e.ctrl = 4'h2;
                else                e.ctrl = 4'h3;
            end
            default: ;
        endcase
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
        end else if (bus.in_valid && pred_ready()) begin
            m_valid <= 1'b1;
            m_exp   <= predict();
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_out_valid", bus.out_valid, m_valid);
            chk("model_in_ready", bus.in_ready, pred_ready());
            if (m_valid) begin
                chk("model_op1", bus.out_op1, m_exp.op1);
                chk("model_op2", bus.out_op2, m_exp.op2);
                chk("model_store_val", bus.out_store_val, m_exp.st);
                chk("model_aluctrl", bus.out_aluctrl, m_exp.ctrl);
                chk("model_funct3", bus.out_funct3, m_exp.f3);
                chk("model_rd", bus.out_rd, m_exp.rd);
                chk("model_reg_we", bus.out_reg_we, m_exp.we);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_opcode   = opc;
        bus.in_funct3   = f3;
        bus.in_funct7_5 = f7;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_rs1_val  = v1;
        bus.in_rs2_val  = v2;
        bus.in_imm      = imm;
        bus.in_pc       = pc;
        bus.in_rd       = rd;
    endtask

    task automatic set_wb(input logic xw, input logic [4:0] xr, input logic [31:0] xv,
                          input logic mw, input logic [4:0] mr, input logic [31:0] mv);
        bus.exmem_we     = xw;
        bus.exmem_rd     = xr;
        bus.exmem_result = xv;
        bus.memwb_we     = mw;
        bus.memwb_rd     = mr;
        bus.memwb_result = mv;
    endtask

    task automatic run_vec(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                           input logic f7, input logic [31:0] e_op1, input logic [31:0] e_op2,
                           input logic [3:0] e_ctrl, input logic e_we);
        issue(opc, f3, f7, 5'd1, 5'd2, 32'h11, 32'hFFFFFF23, 32'hFFFFF804, 32'h1000, 5'd5);
        step();
        chk({nm, "_op1"}, bus.out_op1, e_op1);
        chk({nm, "_op2"}, bus.out_op2, e_op2);
        chk({nm, "_ctrl"}, bus.out_aluctrl, e_ctrl);
        chk({nm, "_we"}, bus.out_reg_we, e_we);
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        issue(OP, 3'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        bus.in_valid  = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) step();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_op1", bus.out_op1, 32'd0);
        chk("rst_op2", bus.out_op2, 32'd0);
        chk("rst_aluctrl", bus.out_aluctrl, 4'd0);
        chk("rst_rd_we", {bus.out_rd, bus.out_reg_we}, 6'd0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        step();

        issue(OP, 3'd0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'h100, 5'd3);
        step();
        chk("add_valid", bus.out_valid, 1'b1);
        chk("add_op1", bus.out_op1, 32'd5);
        chk("add_op2", bus.out_op2, 32'd7);
        chk("add_ctrl", bus.out_aluctrl, 4'b0000);
        chk("add_we", bus.out_reg_we, 1'b1);

        issue(OP_IMM, 3'd5, 1'b1, 5'd1, 5'd5, 32'h80000000, 32'd0, 32'h405, 32'h104, 5'd4);
        step();
        chk("srai_ctrl", bus.out_aluctrl, 4'b1111);
        chk("srai_op2", bus.out_op2, 32'd5);
        issue(OP, 3'd0, 1'b1, 5'd6, 5'd7, 32'd20, 32'd3, 32'd0, 32'h108, 5'd8);
        step();
        chk("sub_ctrl", bus.out_aluctrl, 4'b1000);
        issue(OP_IMM, 3'd0, 1'b1, 5'd6, 5'd3, 32'd20, 32'd0, 32'h423, 32'h10C, 5'd8);
        step();
        chk("addi_f7_ctrl", bus.out_aluctrl, 4'b0000);
        chk("addi_f7_op2", bus.out_op2, 32'h423);

        run_vec("sll",   OP,     3'd1, 1'b0, 32'h11,   32'h3,        4'h1, 1'b1);
        run_vec("slt",   OP,     3'd2, 1'b0, 32'h11,   32'hFFFFFF23, 4'h2, 1'b1);
        run_vec("sltu",  OP,     3'd3, 1'b0, 32'h11,   32'hFFFFFF23, 4'h3, 1'b1);
        run_vec("xor",   OP,     3'd4, 1'b0, 32'h11,   32'hFFFFFF23, 4'h4, 1'b1);
        run_vec("srl",   OP,     3'd5, 1'b0, 32'h11,   32'h3,        4'h5, 1'b1);
        run_vec("sra",   OP,     3'd5, 1'b1, 32'h11,   32'h3,        4'hF, 1'b1);
        run_vec("or",    OP,     3'd6, 1'b0, 32'h11,   32'hFFFFFF23, 4'h6, 1'b1);
        run_vec("and",   OP,     3'd7, 1'b0, 32'h11,   32'hFFFFFF23, 4'h7, 1'b1);
        run_vec("slli",  OP_IMM, 3'd1, 1'b0, 32'h11,   32'h4,        4'h1, 1'b1);
        run_vec("sltiu", OP_IMM, 3'd3, 1'b0, 32'h11,   32'hFFFFF804, 4'h3, 1'b1);
        run_vec("load",  LOAD,   3'd2, 1'b0, 32'h11,   32'hFFFFF804, 4'h0, 1'b1);
        run_vec("store", STORE,  3'd2, 1'b0, 32'h11,   32'hFFFFF804, 4'h0, 1'b0);
        chk("store_val", bus.out_store_val, 32'hFFFFFF23);
        run_vec("jalr",  JALR,   3'd0, 1'b0, 32'h11,   32'hFFFFF804, 4'h0, 1'b1);
        run_vec("lui",   LUI,    3'd0, 1'b0, 32'h0,    32'hFFFFF804, 4'h0, 1'b1);
        run_vec("auipc", AUIPC,  3'd0, 1'b0, 32'h1000, 32'hFFFFF804, 4'h0, 1'b1);
        run_vec("jal",   JAL,    3'd0, 1'b0, 32'h1000, 32'hFFFFF804, 4'h0, 1'b1);
        run_vec("beq",   BRANCH, 3'd0, 1'b0, 32'h11,   32'hFFFFFF23, 4'h8, 1'b0);
        run_vec("bne",   BRANCH, 3'd1, 1'b0, 32'h11,   32'hFFFFFF23, 4'h8, 1'b0);
        run_vec("bge",   BRANCH, 3'd5, 1'b0, 32'h11,   32'hFFFFFF23, 4'h2, 1'b0);
        run_vec("bltu",  BRANCH, 3'd6, 1'b0, 32'h11,   32'hFFFFFF23, 4'h3, 1'b0);
        run_vec("unk",   7'h7F,  3'd0, 1'b0, 32'h11,   32'hFFFFFF23, 4'h0, 1'b0);
        bus.in_valid = 1'b0;
        step();

`ifdef FWD_EN
        set_wb(1'b1, 5'd1, 32'hA, 1'b1, 5'd1, 32'hB);
        issue(OP, 3'd0, 1'b0, 5'd1, 5'd2, 32'h55, 32'h7, 32'd0, 32'h200, 5'd9);
        step();
        chk("fwd_exmem_op1", bus.out_op1, 32'hA);
        set_wb(1'b0, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
        step();
        chk("fwd_memwb_op2", bus.out_op2, 32'hB);
        chk("fwd_memwb_store", bus.out_store_val, 32'hB);
        set_wb(1'b1, 5'd4, 32'hC, 1'b0, 5'd0, 32'd0);
        issue(OP, 3'd0, 1'b0, 5'd4, 5'd2, 32'h44, 32'h7, 32'd0, 32'h204, 5'd9);
        #1;
        chk("fwd_no_stall", bus.in_ready, 1'b1);
        step();
        chk("fwd_rs4_op1", bus.out_op1, 32'hC);
`else
        bus.in_valid = 1'b0;
        step();
        set_wb(1'b1, 5'd4, 32'hC, 1'b0, 5'd0, 32'd0);
        issue(OP, 3'd0, 1'b0, 5'd4, 5'd2, 32'h44, 32'h7, 32'd0, 32'h204, 5'd9);
        #1;
        chk("stall_in_ready", bus.in_ready, 1'b0);
        step();
        chk("stall_in_ready_2", bus.in_ready, 1'b0);
        chk("stall_no_emit", bus.out_valid, 1'b0);
        bus.exmem_we = 1'b0;
        #1;
        chk("stall_release", bus.in_ready, 1'b1);
        step();
        chk("stall_capture_valid", bus.out_valid, 1'b1);
        chk("stall_capture_op1", bus.out_op1, 32'h44);
        set_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hB);
        issue(OP_IMM, 3'd0, 1'b0, 5'd1, 5'd2, 32'h1, 32'h0, 32'h9, 32'h208, 5'd9);
        #1;
        chk("opimm_rs2_unused", bus.in_ready, 1'b1);
        issue(OP, 3'd0, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 32'h20C, 5'd9);
        step();
        chk("memwb_stall", bus.in_ready, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("flush_beats_stall", bus.in_ready, 1'b1);
        step();
        chk("flush_stall_valid", bus.out_valid, 1'b0);
        bus.flush = 1'b0;
`endif
        set_wb(1'b1, 5'd0, 32'hA, 1'b1, 5'd0, 32'hB);
        issue(OP, 3'd0, 1'b0, 5'd0, 5'd0, 32'h55, 32'h66, 32'd0, 32'h210, 5'd9);
        #1;
        chk("rd0_in_ready", bus.in_ready, 1'b1);
        step();
        chk("rd0_op1", bus.out_op1, 32'h55);
        chk("rd0_op2", bus.out_op2, 32'h66);
        set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        issue(OP, 3'd0, 1'b0, 5'd1, 5'd2, 32'h31, 32'h2, 32'd0, 32'h300, 5'd7);
        step();
        bus.out_ready = 1'b0;
        issue(OP, 3'd0, 1'b0, 5'd1, 5'd2, 32'h41, 32'h2, 32'd0, 32'h304, 5'd8);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_op1", bus.out_op1, 32'h31);
            chk("hold_rd", bus.out_rd, 5'd7);
            chk("hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("unhold_in_ready", bus.in_ready, 1'b1);
        step();
        chk("b2b_op1_a", bus.out_op1, 32'h41);
        chk("b2b_rd_a", bus.out_rd, 5'd8);
        issue(OP, 3'd0, 1'b0, 5'd1, 5'd2, 32'h51, 32'h2, 32'd0, 32'h308, 5'd9);
        step();
        chk("b2b_op1_b", bus.out_op1, 32'h51);
        bus.in_valid = 1'b0;
        step();
        chk("drain_valid", bus.out_valid, 1'b0);

        issue(OP, 3'd0, 1'b0, 5'd1, 5'd2, 32'h61, 32'h2, 32'd0, 32'h400, 5'd10);
        step();
        issue(OP, 3'd0, 1'b0, 5'd1, 5'd2, 32'h71, 32'h2, 32'd0, 32'h404, 5'd11);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", bus.in_ready, 1'b1);
        step();
        chk("flush_valid", bus.out_valid, 1'b0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("flush_nothing_emitted", bus.out_valid, 1'b0);

        issue(OP, 3'd0, 1'b0, 5'd1, 5'd2, 32'h81, 32'h2, 32'd0, 32'h500, 5'd12);
        bus.out_ready = 1'b0;
        step();
        chk("pre_reset_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", bus.out_valid, 1'b0);
        chk("async_reset_op1", bus.out_op1, 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (2) step();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
